// File: rtl/mbus_pkg.sv
// mbus_pkg: shared FSM encoding, access-size constants and byte-lane helpers for the memory bus
package mbus_pkg;
  typedef enum logic [1:0] {IDLE, WDATA, RLAT, RDRV} state_e;
  localparam logic WORD = 1'b1;
  localparam logic BYTE = 1'b0;
  function automatic logic [1:0] byte_en(input logic size, input logic a0);
    return (size == WORD) ? 2'b11 : (a0 ? 2'b10 : 2'b01);
  endfunction
  function automatic logic [15:0] rd_fmt(input logic [15:0] w, input logic size, input logic a0);
    return (size == WORD) ? w : {8'h00, a0 ? w[15:8] : w[7:0]};
  endfunction
endpackage

// File: rtl/mbus_ram.sv
// mbus_ram: single-port synchronous word array with byte enables and no reset
module mbus_ram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem_q [2**AW];
  // read-first port: byte-lane writes plus registered read of the addressed word
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i && be_i[0]) mem_q[addr_i][7:0] <= wdata_i[7:0];
      if (we_i && be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/mbus_mem.sv
// mbus_mem: bus-side FSM, address/size latches and output registers in front of mbus_ram
module mbus_mem
  import mbus_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        CLOCK,
  input  logic        _RESET,
  input  logic        MREAD,
  input  logic        MWRITE,
  input  logic        MWORD,
  input  logic [15:0] MD,
  output logic [15:0] MQ,
  output logic        DENA,
  output logic        BUSY,
  output logic        PROTERR
);
  state_e      state_q;
  logic [AW:0] addr_q;
  logic        word_q;
  logic [15:0] mq_q;
  logic        dena_q;
  logic        perr_q;
  logic [15:0] rdata;
  logic        rd_acc;
  logic        unused_md;
  assign unused_md = ^MD[15:AW+1];
  // a read is launched into the RAM straight from the address phase so data is ready in RLAT
  assign rd_acc = (state_q == IDLE) && MREAD && !MWRITE;
  mbus_ram #(.AW(AW)) u_ram (
    .clk_i   (CLOCK),
    .en_i    (rd_acc || state_q == WDATA),
    .we_i    (state_q == WDATA),
    .be_i    (byte_en(word_q, addr_q[0])),
    .addr_i  (state_q == IDLE ? MD[AW:1] : addr_q[AW:1]),
    .wdata_i (word_q == WORD ? MD : {MD[7:0], MD[7:0]}),
    .rdata_o (rdata)
  );
  // transaction FSM; MQ/DENA are registered and MQ is forced to zero whenever DENA is low
  always_ff @(posedge CLOCK or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= WORD;
      mq_q    <= '0;
      dena_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      dena_q <= 1'b0;
      mq_q   <= '0;
      case (state_q)
        IDLE: begin
          if (MREAD && MWRITE) perr_q <= 1'b1;
          else if (MREAD || MWRITE) begin
            state_q <= MREAD ? RLAT : WDATA;
            addr_q  <= MD[AW:0];
            word_q  <= MWORD;
          end
        end
        RLAT: begin
          state_q <= RDRV;
          dena_q  <= 1'b1;
          mq_q    <= rd_fmt(rdata, word_q, addr_q[0]);
        end
        default: state_q <= IDLE;
      endcase
      if (state_q != IDLE && (MREAD || MWRITE)) perr_q <= 1'b1;
    end
  end
  assign MQ      = mq_q;
  assign DENA    = dena_q;
  assign BUSY    = state_q != IDLE;
  assign PROTERR = perr_q;
endmodule

// File: doc/mbus_mem.md
MBUS_MEM -- requirements
Module: mbus_mem

Interface
REQ-001 SHALL have parameter AW, default 10: log2 of memory depth in 16-bit words.
REQ-002 SHALL have port CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port _RESET  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port MREAD  input  1  initiator read request, address phase.
REQ-005 SHALL have port MWRITE  input  1  initiator write request, address phase.
REQ-006 SHALL have port MWORD  input  1  1 = 16-bit access, 0 = byte access; sampled in address phase.
REQ-007 SHALL have port MD  input  16  initiator data: address in address phase, write data in data phase.
REQ-008 SHALL have port MQ  output  16  read data to initiator.
REQ-009 SHALL have port DENA  output  1  high while MQ carries valid read data.
REQ-010 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-011 SHALL have port PROTERR  output  1  sticky protocol-error flag.

Function
REQ-012 SHALL hold a 2**AW x 16 word array; word index = MD[AW:1]; MD[15:AW+1] ignored, so addresses wrap modulo 2**(AW+1) bytes.
REQ-013 SHALL implement FSM states IDLE, WDATA, RLAT, RDRV.
REQ-014 IDLE + MREAD=1, MWRITE=0: latch address and MWORD; go to RLAT.
REQ-015 IDLE + MWRITE=1, MREAD=0: latch address and MWORD; go to WDATA.
REQ-016 WDATA: on the next cycle after the address phase, MD is write data; write the array; return to IDLE.
REQ-017 Word write: store MD[15:0] into the addressed word; address bit 0 ignored.
REQ-018 Byte write: addr[0]=0 stores MD[7:0] into bits 7:0; addr[0]=1 stores MD[7:0] into bits 15:8; other byte unchanged.
REQ-019 RLAT: registered array read; go to RDRV.
REQ-020 RDRV: DENA=1 for exactly one cycle; MQ = read data; return to IDLE. Read latency: address phase at cycle T -> DENA high at T+2.
REQ-021 Word read: MQ = full word. Byte read: MQ[7:0] = selected byte per addr[0], MQ[15:8] = 0.
REQ-022 MQ SHALL be 16'h0000 whenever DENA=0.
REQ-023 MREAD and MWRITE both high in IDLE: no access, stay IDLE, set PROTERR.
REQ-024 MREAD or MWRITE high in WDATA, RLAT or RDRV: request dropped, set PROTERR; current transaction completes unchanged. In WDATA, MD is still taken as write data.
REQ-025 Back-to-back throughput: a new request is accepted in the cycle immediately after return to IDLE. Max rate: one read per 3 cycles, one write per 2 cycles.
REQ-026 PROTERR SHALL clear only on reset.

Reset
REQ-027 _RESET low SHALL force IDLE, DENA=0, MQ=0, BUSY=0, PROTERR=0 immediately, independent of CLOCK.
REQ-028 Reset mid-transaction SHALL abort it: a pending write is not performed and no DENA pulse follows.
REQ-029 Array contents SHALL NOT be cleared by reset.

Structure
REQ-030 FSM state encoding and the access-size constants (WORD, BYTE) SHALL live in shared package mbus_pkg, for reuse by the initiator-side bench.
REQ-031 The array SHALL be a sub-module mbus_ram: single-port, synchronous read and write, byte-enable pair, no reset, so it infers block RAM.
REQ-032 mbus_mem SHALL hold only the FSM, the address/size latches and the output registers.

Verification
REQ-033 Word write then read: write 16'h1234 to addr 16'h0040; read 16'h0040 -> DENA at T+2, MQ=16'h1234, DENA low at T+3.
REQ-034 Byte lanes: word-write 16'hAAAA to 16'h0010, byte-write 8'h55 to 16'h0011 -> word read gives 16'h55AA; byte read of 16'h0010 gives 16'h00AA.
REQ-035 Wrap: with AW=10, write 16'hBEEF to 16'h0802; read 16'h0002 -> MQ=16'hBEEF.
REQ-036 Protocol error: MREAD and MWRITE high together in IDLE -> PROTERR=1, BUSY stays 0, no DENA. MREAD asserted in RLAT -> original read returns correct data, no second DENA.
REQ-037 Reset abort: assert _RESET low during WDATA -> target word keeps its old value; DENA, BUSY and PROTERR are 0 asynchronously.
REQ-038 Throughput: 8 back-to-back reads, each issued on the cycle BUSY falls -> 8 DENA pulses 3 cycles apart, PROTERR=0.
